module_load_unit: RTL
=====================

MODULE_LOAD_UNIT -- requirements
Module: module_load_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15: number of READ cycles without mem_ack before a timeout error.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  load request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_addr  input  32  byte address of load.
REQ-007 req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 mem_re  output  1  memory read strobe.
REQ-009 mem_addr  output  32  word-aligned read address.
REQ-010 mem_rdata  input  32  memory read data; valid when mem_ack=1.
REQ-011 mem_ack  input  1  memory read completion.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_data  output  32  extended load result.
REQ-015 rsp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, READ, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1.
REQ-018 On acceptance, req_addr and req_funct3 SHALL be registered; later changes on req_* are ignored until the next IDLE.
REQ-019 Accepted funct3 not in {000,001,010,100,101} SHALL go IDLE->RESP with rsp_err=10, rsp_data=0, and no mem_re pulse.
REQ-020 Misaligned request (LH/LHU with addr[0]=1; LW with addr[1:0]!=00) SHALL go IDLE->RESP with rsp_err=01, rsp_data=0, and no mem_re pulse; illegal funct3 takes priority over misalignment.
REQ-021 Legal aligned request SHALL go IDLE->READ; in READ, mem_re=1 and mem_addr={addr[31:2],2'b00} are held constant every cycle until exit.
REQ-022 In READ, mem_ack=1 SHALL capture and extend mem_rdata and move to RESP with rsp_err=00; rsp_valid rises the cycle after the ack.
REQ-023 In READ, a wait counter SHALL count cycles without ack; if MAX_WAIT cycles pass without mem_ack, the FSM moves to RESP with rsp_err=11 and rsp_data=0. An ack on the final cycle wins over timeout.
REQ-024 Minimum latency: accept at cycle N, mem_re=1 at N+1, ack at N+1, rsp_valid=1 at N+2.
REQ-025 Lane selection is little-endian: byte = mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]]; half = mem_rdata[16*addr[1]+15 : 16*addr[1]].
REQ-026 Extension: LB/LH sign-extend bit 7/15 to 32 bits; LBU/LHU zero-extend; LW passes 32 bits unchanged.
REQ-027 In RESP, rsp_valid=1, and rsp_data/rsp_err SHALL stay stable until rsp_valid=1 and rsp_ready=1, then go to IDLE. Back-to-back: the next request is accepted no earlier than the cycle after the handshake.
REQ-028 mem_ack outside READ SHALL be ignored.
REQ-029 mem_re SHALL be 0 in IDLE and RESP.

Reset
REQ-030 While reset=1, and asynchronously on its assertion: state=IDLE, wait counter=0, req_ready=1, mem_re=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=00.
REQ-031 Reset asserted in READ or RESP SHALL abort the transaction; no response is produced for it, and a late mem_ack after reset is ignored.

Verification
REQ-032 LB addr=0x103, mem_rdata=0x8F00_0000, ack in first READ cycle -> mem_addr=0x100, rsp_data=0xFFFF_FF8F, rsp_err=00, rsp_valid at N+2.
REQ-033 LBU addr=0x103 and LHU addr=0x102 with mem_rdata=0x8F0F_1234 -> 0x0000_008F and 0x0000_8F0F; LH addr=0x100 -> 0x0000_1234.
REQ-034 LW addr=0x102 -> rsp_err=01, no mem_re; funct3=011 -> rsp_err=10, no mem_re; funct3=111 with addr=0x101 -> rsp_err=10.
REQ-035 LW addr=0x200 with mem_ack held low -> rsp_err=11 after exactly MAX_WAIT=15 READ cycles; mem_re stays 1 and mem_addr=0x200 throughout.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable and req_ready=0; handshake -> req_ready=1 on the next cycle.
REQ-037 Reset pulse mid-READ, then mem_ack=1 -> outputs at reset values, no rsp_valid; a fresh LW then completes normally.

Source files
------------

// File: rtl/module_load_unit_if.sv
// Bus bundle for the load unit: request, memory read port and response.
interface module_load_unit_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_funct3;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_err;

  modport master (
    output req_valid, req_addr, req_funct3, mem_rdata, mem_ack, rsp_ready,
    input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rdata, mem_ack, rsp_ready,
    output req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/module_load_unit.sv
// Single-request load unit: checks legality/alignment, reads one word,
// selects the byte/half lane and extends it, with a read timeout.
module module_load_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  module_load_unit_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    addr_lo;
  logic [2:0]    funct3_q;
  logic          req_ready_q;
  logic          mem_re_q;
  logic [31:0]   mem_addr_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic [1:0]    rsp_err_q;

  logic          f3_illegal;
  logic          f3_misaligned;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [DW-1:0] ext_data;

  // Legality and alignment of the request currently presented.
  always_comb begin
    f3_illegal    = 1'b1;
    f3_misaligned = 1'b0;
    unique case (bus.req_funct3)
      F3_LB, F3_LBU: f3_illegal = 1'b0;
      F3_LH, F3_LHU: begin
        f3_illegal    = 1'b0;
        f3_misaligned = bus.req_addr[0];
      end
      F3_LW: begin
        f3_illegal    = 1'b0;
        f3_misaligned = (bus.req_addr[1:0] != 2'b00);
      end
      default: f3_illegal = 1'b1;
    endcase
  end

  // Little-endian lane select and extension using the registered request.
  always_comb begin
    lane_b   = bus.mem_rdata[{addr_lo, 3'b000} +: 8];
    lane_h   = bus.mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    ext_data = '0;
    unique case (funct3_q)
      F3_LB:   ext_data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   ext_data = {{16{lane_h[15]}}, lane_h};
      F3_LW:   ext_data = bus.mem_rdata;
      F3_LBU:  ext_data = {24'h0, lane_b};
      F3_LHU:  ext_data = {16'h0, lane_h};
      default: ext_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      addr_lo     <= '0;
      funct3_q    <= '0;
      req_ready_q <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_lo     <= bus.req_addr[1:0];
            funct3_q    <= bus.req_funct3;
            req_ready_q <= 1'b0;
            wait_cnt    <= '0;
            if (f3_illegal || f3_misaligned) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= f3_illegal ? ERR_ILL : ERR_MIS;
            end else begin
              state      <= READ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {bus.req_addr[31:2], 2'b00};
            end
          end
        end
        READ: begin
          // Ack on the last allowed cycle is checked first so it wins over timeout.
          if (bus.mem_ack) begin
            state       <= RESP;
            mem_re_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ext_data;
            rsp_err_q   <= ERR_OK;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            state       <= RESP;
            mem_re_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_TOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
